// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered output stage behind the 3-bit mini arithmetic unit.
//
//   For every accepted result, this stage:
//   - derives the status flags {V,C,N,Z};
//   - queues the result together with its flags in a small FIFO,
//     with a valid/ready handshake on both sides;
//   - keeps a saturating count of signed-overflow (V=1) results.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     in_valid / in_ready     upstream handshake (in_ready = not full)
//     in_sum, in_carry        arithmetic unit result and carry out
//     in_op                   {s1,s0} op select used for this result
//     in_a_msb, in_b_msb      sign bits of operands a and b
//     out_valid / out_ready   downstream handshake for the head entry
//     out_result, out_flags   head entry result and flags {V,C,N,Z}
//                             (both read 0 while the FIFO is empty)
//     ovf_clr                 synchronous clear of the overflow counter
//     ovf_count               saturating count of accepted V=1 entries

module alu_result_stage #(
  parameter int WIDTH     = 3,
  parameter int DEPTH     = 2,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sum,
  input  logic                 in_carry,
  input  logic [1:0]           in_op,
  input  logic                 in_a_msb,
  input  logic                 in_b_msb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [3:0]           out_flags,
  input  logic                 ovf_clr,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]       PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [OVF_CNT_W-1:0] CNT_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;

  // Pointers carry one extra wrap bit so that full and empty can be told
  // apart when the index bits are equal.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] result_mem [DEPTH];
  logic [3:0]       flags_mem  [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  logic flag_z;
  logic flag_n;
  logic flag_c;
  logic flag_v;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // in_ready comes from registered state only. A full FIFO therefore
  // refuses a push even in a cycle where the head is being popped.
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Flags for the incoming result. The overflow rule depends on which
  // operation produced the sum:
  //   - a-1 can only overflow from the most-negative a;
  //   - -b can only overflow from the most-negative b.
  // C is the raw carry; for the subtracting ops it means "no borrow".
  always_comb begin
    flag_z = (in_sum == '0);
    flag_n = in_sum[WIDTH-1];
    flag_c = in_carry;
    flag_v = 1'b0;
    case (in_op)
      2'b00: flag_v = in_a_msb && !in_sum[WIDTH-1];
      2'b01: flag_v = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb);
      2'b10: flag_v = (in_a_msb != in_b_msb) && (in_sum[WIDTH-1] != in_a_msb);
      2'b11: flag_v = in_b_msb && in_sum[WIDTH-1];
      default: flag_v = 1'b0;
    endcase
  end

  // FIFO pointers and storage. Reset discards every stored entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        result_mem[i] <= '0;
        flags_mem[i]  <= '0;
      end
    end else begin
      if (push) begin
        result_mem[wr_ptr[PTR_W-1:0]] <= in_sum;
        flags_mem[wr_ptr[PTR_W-1:0]]  <= {flag_v, flag_c, flag_n, flag_z};
        wr_ptr                        <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // The head entry is masked to zero while the FIFO is empty, so stale
  // storage never shows on the outputs.
  always_comb begin
    out_result = '0;
    out_flags  = '0;
    if (!empty) begin
      out_result = result_mem[rd_ptr[PTR_W-1:0]];
      out_flags  = flags_mem[rd_ptr[PTR_W-1:0]];
    end
  end

  // Overflow event counter.
  // - It saturates at all-ones instead of wrapping.
  // - A clear in the same cycle as an overflowing push leaves the count
  //   at 1: the clear happens first, then the push is counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= (push && flag_v) ? CNT_ONE : '0;
    end else if (push && flag_v && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage
//   Self-checking bench for alu_result_stage.
//
//   The reference model computes each result with plain signed/unsigned
//   arithmetic on the operands a and b. From that arithmetic it derives:
//   - the unit's sum and carry, which are fed to the DUT as stimulus;
//   - the expected flags, with V meaning "the true signed result does
//     not fit in 3 bits".
//   A queue holds the expected FIFO contents.

module tb_alu_result_stage;

  localparam int WIDTH     = 3;
  localparam int DEPTH     = 2;
  localparam int OVF_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_sum;
  logic                 in_carry;
  logic [1:0]           in_op;
  logic                 in_a_msb;
  logic                 in_b_msb;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic [3:0]           out_flags;
  logic                 ovf_clr;
  logic [OVF_CNT_W-1:0] ovf_count;

  logic [6:0] exp_q [$];
  int         ovf_model = 0;
  int         checks    = 0;
  int         failures  = 0;

  always #5 clk = ~clk;

  alu_result_stage #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .OVF_CNT_W(OVF_CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sum(in_sum),
    .in_carry(in_carry),
    .in_op(in_op),
    .in_a_msb(in_a_msb),
    .in_b_msb(in_b_msb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_flags(out_flags),
    .ovf_clr(ovf_clr),
    .ovf_count(ovf_count)
  );

  // Behaviour of the arithmetic unit plus the ideal signed result.
  // Returns {V, carry, sum[2:0]}.
  function automatic logic [4:0] unitModel(input logic [2:0] a, input logic [2:0] b,
                                           input logic [1:0] op);
    int ua;
    int ub;
    int sa;
    int sb;
    int raw;
    int ideal;
    logic v;
    logic carry;
    logic [2:0] sum;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 4) ? ua - 8 : ua;
    sb = (ub >= 4) ? ub - 8 : ub;
    case (op)
      2'd0: begin raw = ua + 7;              ideal = sa - 1;  end
      2'd1: begin raw = ua + ub;             ideal = sa + sb; end
      2'd2: begin raw = ua + (7 - ub) + 1;   ideal = sa - sb; end
      default: begin raw = (7 - ub) + 1;     ideal = -sb;     end
    endcase
    v     = (ideal < -4) || (ideal > 3);
    carry = (raw >= 8);
    sum   = 3'(raw % 8);
    return {v, carry, sum};
  endfunction

  // Drive one cycle of inputs, then advance the model across the clock edge.
  task automatic applyStimulus(input logic valid, input logic [2:0] a, input logic [2:0] b,
                               input logic [1:0] op, input logic ordy, input logic clr);
    logic [4:0] u;
    logic [3:0] fl;
    logic       do_push;
    logic       do_pop;
    u         = unitModel(a, b, op);
    fl        = {u[4], u[3], u[2], (u[2:0] == 3'd0)};
    in_valid  = valid;
    in_sum    = u[2:0];
    in_carry  = u[3];
    in_op     = op;
    in_a_msb  = a[2];
    in_b_msb  = b[2];
    out_ready = ordy;
    ovf_clr   = clr;
    do_push   = valid && (exp_q.size() < DEPTH);
    do_pop    = ordy && (exp_q.size() > 0);
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({fl, u[2:0]});
    if (clr) ovf_model = (do_push && u[4]) ? 1 : 0;
    else if (do_push && u[4] && ovf_model < 255) ovf_model++;
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [6:0] head;
    logic       ev;
    logic       er;
    ev   = (exp_q.size() > 0);
    er   = (exp_q.size() < DEPTH);
    head = ev ? exp_q[0] : 7'd0;
    checkVal({tag, " out_valid"},  {7'd0, out_valid},  {7'd0, ev});
    checkVal({tag, " out_result"}, {5'd0, out_result}, {5'd0, head[2:0]});
    checkVal({tag, " out_flags"},  {4'd0, out_flags},  {4'd0, head[6:3]});
    checkVal({tag, " in_ready"},   {7'd0, in_ready},   {7'd0, er});
    checkVal({tag, " ovf_count"},  ovf_count,          8'(ovf_model));
  endtask

  task automatic pickOverflow(output logic [2:0] a, output logic [2:0] b, output logic [1:0] op);
    logic [4:0] u;
    u = 5'd0;
    for (int i = 0; i < 1000; i++) begin
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      op = 2'($urandom_range(0, 3));
      u = unitModel(a, b, op);
      if (u[4]) break;
    end
    if (!u[4]) begin
      a = 3'd2;
      b = 3'd3;
      op = 2'd1;
    end
  endtask

  initial begin
    logic [2:0] ra;
    logic [2:0] rb;
    logic [1:0] rop;

    in_valid = 1'b0;
    in_sum = '0;
    in_carry = 1'b0;
    in_op = 2'd0;
    in_a_msb = 1'b0;
    in_b_msb = 1'b0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;

    // Power-on reset
    #12;
    checkOutput("por");
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Reset with two overflowing entries queued
    applyStimulus(1'b1, 3'd2, 3'd3, 2'd1, 1'b0, 1'b0);
    checkOutput("pre_reset1");
    applyStimulus(1'b1, 3'd2, 3'd3, 2'd1, 1'b0, 1'b0);
    checkOutput("pre_reset2");
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    exp_q.delete();
    ovf_model = 0;
    checkOutput("mid_reset");
    #3;
    rst_n = 1'b1;

    // First-result latency: 2+3 = 5 overflows
    applyStimulus(1'b1, 3'd2, 3'd3, 2'd1, 1'b0, 1'b0);
    checkOutput("latency");
    checkVal("latency result", {5'd0, out_result}, 8'd5);
    checkVal("latency flags", {4'd0, out_flags}, 8'b1010);
    checkVal("latency ovf", ovf_count, 8'd1);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("drain0");
    checkVal("ovf hold", ovf_count, 8'd1);

    // Negate most-negative b, then an ordinary b
    applyStimulus(1'b1, 3'd0, 3'd4, 2'd3, 1'b1, 1'b0);
    checkOutput("neg_min");
    checkVal("neg_min flags", {4'd0, out_flags}, 8'b1010);
    applyStimulus(1'b1, 3'd0, 3'd2, 2'd3, 1'b1, 1'b0);
    checkOutput("neg_two");
    checkVal("neg_two flags", {4'd0, out_flags}, 8'b0010);

    // Decrement most-negative a, then a=1
    applyStimulus(1'b1, 3'd4, 3'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("dec_min");
    checkVal("dec_min result", {5'd0, out_result}, 8'd3);
    checkVal("dec_min flags", {4'd0, out_flags}, 8'b1100);
    applyStimulus(1'b1, 3'd1, 3'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("dec_one");
    checkVal("dec_one flags", {4'd0, out_flags}, 8'b0101);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("drain1");

    // Backpressure: results 1, 2, 3 with consumer stalled
    applyStimulus(1'b1, 3'd0, 3'd1, 2'd1, 1'b0, 1'b0);
    checkOutput("bp1");
    applyStimulus(1'b1, 3'd0, 3'd2, 2'd1, 1'b0, 1'b0);
    checkOutput("bp2");
    checkVal("bp full in_ready", {7'd0, in_ready}, 8'd0);
    applyStimulus(1'b1, 3'd0, 3'd3, 2'd1, 1'b0, 1'b0);
    checkOutput("bp3");
    checkVal("bp head", {5'd0, out_result}, 8'd1);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("bp_pop1");
    checkVal("bp second", {5'd0, out_result}, 8'd2);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("bp_pop2");
    applyStimulus(1'b1, 3'd0, 3'd3, 2'd1, 1'b1, 1'b0);
    checkOutput("bp_repush");
    checkVal("bp third", {5'd0, out_result}, 8'd3);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("bp_empty");

    // Simultaneous push/pop around occupancy 1 with random consumer
    applyStimulus(1'b1, 3'd1, 3'd1, 2'd1, 1'b0, 1'b0);
    checkOutput("occ1_fill");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      checkOutput("occ1_rand");
    end

    // Fully random traffic
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      checkOutput("rand");
    end

    // Overflow counter saturation
    $display("[TB] overflow saturation phase");
    for (int i = 0; i < 260; i++) begin
      pickOverflow(ra, rb, rop);
      applyStimulus(1'b1, ra, rb, rop, 1'b1, 1'b0);
      checkOutput("ovf_sat");
    end
    checkVal("ovf saturated", ovf_count, 8'd255);
    pickOverflow(ra, rb, rop);
    applyStimulus(1'b1, ra, rb, rop, 1'b1, 1'b1);
    checkOutput("ovf_clr_push");
    checkVal("ovf clear+count", ovf_count, 8'd1);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1);
    checkOutput("ovf_clr_only");
    checkVal("ovf cleared", ovf_count, 8'd0);
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
